multi_key_debouncer: RTL and testbench

MULTI_KEY_DEBOUNCER -- requirements
Module: multi_key_debouncer

---
 rtl/multi_key_debouncer.sv | 123 ++++++++++++
 tb/tb_multi_key_debouncer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multi_key_debouncer.sv
// Per-channel key debouncer with press/release/long-press pulses.
// Define KEY_AUTOREPEAT_EN to add the auto-repeat counter and repeat_flag.
module multi_key_debouncer #(
    parameter int N_KEYS     = 4,
    parameter int CNT_MAX    = 2_000_000,
    parameter int CNT_WIDTH  = 21,
    parameter int LONG_MAX   = 100_000_000,
    parameter int REPEAT_MAX = 20_000_000,
    parameter int HOLD_WIDTH = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press_flag,
    output logic [N_KEYS-1:0] release_flag,
    output logic [N_KEYS-1:0] long_flag,
    output logic [N_KEYS-1:0] repeat_flag,
    output logic              any_pressed
);

    localparam logic [CNT_WIDTH-1:0]  DEB_LAST  = CNT_WIDTH'(CNT_MAX - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(LONG_MAX - 1);

    logic [N_KEYS-1:0]     sync_a, sync_b;
    logic [N_KEYS-1:0]     long_seen;
    logic [N_KEYS-1:0]     deb_hit, rise, fall, ks_nxt, long_hit;
    logic [CNT_WIDTH-1:0]  deb_cnt  [N_KEYS];
    logic [HOLD_WIDTH-1:0] hold_cnt [N_KEYS];

    always_comb begin
        deb_hit  = '0;
        rise     = '0;
        fall     = '0;
        ks_nxt   = key_state;
        long_hit = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            deb_hit[i]  = (sync_b[i] != key_state[i]) && (deb_cnt[i] == DEB_LAST);
            rise[i]     = deb_hit[i] && sync_b[i];
            fall[i]     = deb_hit[i] && !sync_b[i];
            ks_nxt[i]   = deb_hit[i] ? sync_b[i] : key_state[i];
            // Long press fires once, one cycle after the hold counter saturates.
            long_hit[i] = key_state[i] && !fall[i] && !long_seen[i] &&
                          (hold_cnt[i] == HOLD_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a       <= '0;
            sync_b       <= '0;
            key_state    <= '0;
            press_flag   <= '0;
            release_flag <= '0;
            long_flag    <= '0;
            long_seen    <= '0;
            any_pressed  <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) begin
                deb_cnt[i]  <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            sync_a       <= key_in;
            sync_b       <= sync_a;
            key_state    <= ks_nxt;
            press_flag   <= rise;
            release_flag <= fall;
            long_flag    <= long_hit;
            any_pressed  <= |ks_nxt;
            for (int i = 0; i < N_KEYS; i++) begin
                if ((sync_b[i] == key_state[i]) || deb_hit[i])
                    deb_cnt[i] <= '0;
                else
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;

                if (!key_state[i] || fall[i]) begin
                    hold_cnt[i]  <= '0;
                    long_seen[i] <= 1'b0;
                end else begin
                    if (hold_cnt[i] != HOLD_LAST)
                        hold_cnt[i] <= hold_cnt[i] + 1'b1;
                    if (long_hit[i])
                        long_seen[i] <= 1'b1;
                end
            end
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [HOLD_WIDTH-1:0] REP_LAST = HOLD_WIDTH'(REPEAT_MAX - 1);

    logic [HOLD_WIDTH-1:0] rep_cnt [N_KEYS];
    logic [N_KEYS-1:0]     rep_run, rep_hit;

    always_comb begin
        rep_run = '0;
        rep_hit = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            rep_run[i] = key_state[i] && !fall[i] && long_seen[i];
            rep_hit[i] = rep_run[i] && (rep_cnt[i] == REP_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            repeat_flag <= '0;
            for (int i = 0; i < N_KEYS; i++)
                rep_cnt[i] <= '0;
        end else begin
            repeat_flag <= rep_hit;
            for (int i = 0; i < N_KEYS; i++) begin
                if (!rep_run[i] || rep_hit[i])
                    rep_cnt[i] <= '0;
                else
                    rep_cnt[i] <= rep_cnt[i] + 1'b1;
            end
        end
    end
`else
    assign repeat_flag = '0;
`endif

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Directed bench for multi_key_debouncer with small debounce/hold windows.
module tb_multi_key_debouncer;

    localparam int N = 4;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] key_in = '0;
    logic [N-1:0] key_state, press_flag, release_flag, long_flag, repeat_flag;
    logic         any_pressed;

    multi_key_debouncer #(
        .N_KEYS(4), .CNT_MAX(8), .CNT_WIDTH(4),
        .LONG_MAX(32), .REPEAT_MAX(10), .HOLD_WIDTH(6)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in),
        .key_state(key_state), .press_flag(press_flag),
        .release_flag(release_flag), .long_flag(long_flag),
        .repeat_flag(repeat_flag), .any_pressed(any_pressed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] key;
        int           cycles;
        logic [N-1:0] st;
        logic [N-1:0] pr;
        logic [N-1:0] rl;
        logic         any;
    } vec_t;

    vec_t vt [21];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt_press [N];
    int   cnt_rel   [N];
    int   cnt_long  [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            cnt_press[i] = 0;
            cnt_rel[i]   = 0;
            cnt_long[i]  = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            cnt_press[i] += int'(press_flag[i]);
            cnt_rel[i]   += int'(release_flag[i]);
            cnt_long[i]  += int'(long_flag[i]);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) begin
            key_in = vt[v].key;
            for (int c = 0; c < vt[v].cycles; c++) step();
            check($sformatf("v%0d_state", v), key_state, vt[v].st);
            check($sformatf("v%0d_press", v), press_flag, vt[v].pr);
            check($sformatf("v%0d_release", v), release_flag, vt[v].rl);
            check($sformatf("v%0d_any", v), any_pressed, vt[v].any);
            check($sformatf("v%0d_long", v), long_flag, 4'b0000);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, key_state, 4'b0000);
        check({tag, "_press"}, press_flag, 4'b0000);
        check({tag, "_release"}, release_flag, 4'b0000);
        check({tag, "_long"}, long_flag, 4'b0000);
        check({tag, "_repeat"}, repeat_flag, 4'b0000);
        check({tag, "_any"}, any_pressed, 1'b0);
    endtask

    initial begin
        // clean press/release on key 0
        vt[0]  = '{4'b0001, 9, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vt[1]  = '{4'b0001, 1, 4'b0001, 4'b0001, 4'b0000, 1'b1};
        vt[2]  = '{4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, 1'b1};
        vt[3]  = '{4'b0001, 9, 4'b0001, 4'b0000, 4'b0000, 1'b1};
        vt[4]  = '{4'b0000, 9, 4'b0001, 4'b0000, 4'b0000, 1'b1};
        vt[5]  = '{4'b0000, 1, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        vt[6]  = '{4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        // bounce on key 1: 5 high / 3 low, four times
        for (int b = 0; b < 4; b++) begin
            vt[7 + 2*b] = '{4'b0010, 5, 4'b0000, 4'b0000, 4'b0000, 1'b0};
            vt[8 + 2*b] = '{4'b0000, 3, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        end
        vt[15] = '{4'b0000, 12, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        // simultaneous keys 0 and 3
        vt[16] = '{4'b1001, 9, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vt[17] = '{4'b1001, 1, 4'b1001, 4'b1001, 4'b0000, 1'b1};
        vt[18] = '{4'b0000, 9, 4'b1001, 4'b0000, 4'b0000, 1'b1};
        vt[19] = '{4'b0000, 1, 4'b0000, 4'b0000, 4'b1001, 1'b0};
        vt[20] = '{4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 1'b0};

        clear_counts();
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;

        clear_counts();
        run_vecs(0, 6);
        check("a_press_count", cnt_press[0], 1);
        check("a_release_count", cnt_rel[0], 1);

        clear_counts();
        run_vecs(7, 15);
        check("b_press_count", cnt_press[1], 0);
        check("b_release_count", cnt_rel[1], 0);

        clear_counts();
        run_vecs(16, 20);
        check("d_press_count0", cnt_press[0], 1);
        check("d_press_count3", cnt_press[3], 1);

        // long press and auto-repeat on key 2
        clear_counts();
        key_in = 4'b0100;
        repeat (9) step();
        check("c_press_early", press_flag, 4'b0000);
        step();
        check("c_press", press_flag, 4'b0100);
        for (int k = 1; k <= 70; k++) begin
            if (k == 51) key_in = 4'b0000;
            step();
            check($sformatf("c_long_k%0d", k), long_flag[2], k == 32);
            check($sformatf("c_repeat_k%0d", k), repeat_flag[2], AR && (k == 42 || k == 52));
            check($sformatf("c_release_k%0d", k), release_flag[2], k == 60);
        end
        check("c_long_count", cnt_long[2], 1);
        check("c_state_after", key_state, 4'b0000);

        // asynchronous reset mid-hold on key 1
        key_in = 4'b0010;
        repeat (15) step();
        check("e_state_before", key_state, 4'b0010);
        check("e_any_before", any_pressed, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("e_async");
        @(posedge clk);
        #1 rst = 1'b0;
        clear_counts();
        repeat (9) step();
        check("e_state_early", key_state, 4'b0000);
        step();
        check("e_state", key_state, 4'b0010);
        check("e_press", press_flag, 4'b0010);
        repeat (5) step();
        check("e_press_count", cnt_press[1], 1);
        check("e_release_count", cnt_rel[1], 0);
        key_in = 4'b0000;
        repeat (12) step();
        check("e_final_state", key_state, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
